// File: rtl/fetch_sequencer_if.sv
// -----------------------------------------------------------------------------
// fetch_sequencer_if
//
// Bundles the two handshake channels of the fetch sequencer:
//   - instruction-memory request/response (imem_req_*, imem_rsp_*)
//   - fetched-instruction hand-off to decode (instr_*)
//
// Modports:
//   master : the sequencer side (drives requests and instructions)
//   slave  : the environment side (memory and decode)
// -----------------------------------------------------------------------------
interface fetch_sequencer_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        output instr_valid,
        output instr_data,
        output instr_pc,
        input  instr_ready
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data,
        input  instr_valid,
        input  instr_data,
        input  instr_pc,
        output instr_ready
    );
endinterface

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//
// Owns the program counter. Issues one instruction-memory read at a time,
// captures the response, and offers the word plus its address to decode.
// Applies branch/jump redirects and a level-sensitive halt.
//
// Parameters:
//   RESET_VECTOR : PC value loaded on reset
//   PC_STEP      : increment applied after each non-squashed fetch
//
// Ports:
//   clk             : rising-edge clock
//   reset           : synchronous, active-high reset
//   bus             : memory request/response and decode channels (master)
//   redirect_valid  : single-cycle pulse, branch/jump taken
//   redirect_target : new PC, low two bits dropped
//   halt            : stop fetching at the next instruction boundary
//   halted          : sequencer stopped (leaves only through reset)
//   pc              : current fetch PC
// -----------------------------------------------------------------------------
module fetch_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] PC_STEP      = 32'd4
) (
    input  logic                clk,
    input  logic                reset,
    fetch_sequencer_if.master   bus,
    input  logic                redirect_valid,
    input  logic [31:0]         redirect_target,
    input  logic                halt,
    output logic                halted,
    output logic [31:0]         pc
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_RSP,
        HOLD,
        HALTED
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        squash_q, squash_d;
    logic [31:0] instr_data_q;
    logic [31:0] instr_pc_q;
    logic        capture;
    logic [31:0] redirect_pc;

    // Word-aligned redirect target.
    assign redirect_pc = redirect_target & 32'hFFFF_FFFC;

    // -------------------------------------------------------------------------
    // Next-state and datapath control
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_d  = state_q;
        pc_d     = pc_q;
        squash_d = squash_q;
        capture  = 1'b0;

        case (state_q)
            IDLE: begin
                // Redirect beats halt in the same cycle.
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = REQ;
                end else begin
                    state_d = halt ? HALTED : REQ;
                end
            end

            REQ: begin
                // The address may change while the request is unaccepted.
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                end
                if (bus.imem_req_ready) begin
                    state_d = WAIT_RSP;
                    // The old address was accepted; its response is stale.
                    squash_d = redirect_valid;
                end
            end

            WAIT_RSP: begin
                if (bus.imem_rsp_valid) begin
                    if (squash_q || redirect_valid) begin
                        // Stale response: drop it and fetch from pc, which
                        // already holds the latest target.
                        squash_d = 1'b0;
                        state_d  = REQ;
                        if (redirect_valid) begin
                            pc_d = redirect_pc;
                        end
                    end else begin
                        capture = 1'b1;
                        pc_d    = pc_q + PC_STEP;
                        state_d = HOLD;
                    end
                end else if (redirect_valid) begin
                    squash_d = 1'b1;
                    pc_d     = redirect_pc;
                end
            end

            HOLD: begin
                if (redirect_valid) begin
                    // Held instruction is on the wrong path; drop it whether
                    // or not decode took it this cycle.
                    pc_d    = redirect_pc;
                    state_d = REQ;
                end else if (bus.instr_ready) begin
                    state_d = halt ? HALTED : REQ;
                end
            end

            HALTED: begin
                state_d = HALTED;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the values
        // from before this edge, independent of statement order.
        if (reset) begin
            state_q      <= IDLE;
            pc_q         <= RESET_VECTOR;
            squash_q     <= 1'b0;
            instr_data_q <= '0;
            instr_pc_q   <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            squash_q <= squash_d;
            if (capture) begin
                instr_data_q <= bus.imem_rsp_data;
                instr_pc_q   <= pc_q;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: registers or direct state decode only
    // -------------------------------------------------------------------------
    assign bus.imem_req_valid = (state_q == REQ);
    assign bus.imem_req_addr  = pc_q;
    assign bus.instr_valid    = (state_q == HOLD);
    assign bus.instr_data     = instr_data_q;
    assign bus.instr_pc       = instr_pc_q;
    assign halted             = (state_q == HALTED);
    assign pc                 = pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Self-checking bench for fetch_sequencer. A behavioural model of the fetch
// protocol plus a memory responder live in the bench; a negedge process
// compares every DUT output to the model each cycle. Directed phases pin the
// model with literal expectations, then a randomized phase runs long.
// A second instance with RESET_VECTOR = FFFF_FFF8 covers the PC wrap.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

    localparam logic [31:0] DATA_MASK = 32'hA5A5_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT
    fetch_sequencer_if ifc ();
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        halt;
    logic        halted;
    logic [31:0] pc;

    fetch_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .bus             (ifc),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .halt            (halt),
        .halted          (halted),
        .pc              (pc)
    );

    // Wrap-around instance
    fetch_sequencer_if ifw ();
    logic        reset_w;
    logic        redirect_valid_w;
    logic [31:0] redirect_target_w;
    logic        halt_w;
    logic        halted_w;
    logic [31:0] pc_w;

    fetch_sequencer #(
        .RESET_VECTOR (32'hFFFF_FFF8),
        .PC_STEP      (32'd4)
    ) dut_wrap (
        .clk             (clk),
        .reset           (reset_w),
        .bus             (ifw),
        .redirect_valid  (redirect_valid_w),
        .redirect_target (redirect_target_w),
        .halt            (halt_w),
        .halted          (halted_w),
        .pc              (pc_w)
    );

    int vectors    = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Behavioural model: what the sequencer is doing, as independent flags
    // -------------------------------------------------------------------------
    bit          m_boot, m_req, m_wait, m_drop, m_have, m_halt;
    logic [31:0] m_pc, m_ipc, m_idata;
    bit          chk_en = 1'b0;

    task automatic model_step();
        bit          redir;
        logic [31:0] tgt;
        if (reset) begin
            m_boot = 1; m_req = 0; m_wait = 0; m_drop = 0; m_have = 0; m_halt = 0;
            m_pc = 32'h0; m_ipc = 32'h0; m_idata = 32'h0;
            return;
        end
        if (m_halt) return;
        redir = redirect_valid;
        tgt   = redirect_target & 32'hFFFF_FFFC;
        if (m_boot) begin
            m_boot = 0;
            if (halt && !redir) m_halt = 1;
            else                m_req  = 1;
        end else if (m_req) begin
            if (ifc.imem_req_ready) begin
                m_req = 0; m_wait = 1; m_drop = redir;
            end
        end else if (m_wait) begin
            if (ifc.imem_rsp_valid) begin
                m_wait = 0;
                if (m_drop || redir) begin
                    m_req = 1; m_drop = 0;
                end else begin
                    m_have = 1; m_ipc = m_pc; m_idata = ifc.imem_rsp_data;
                    m_pc = m_pc + 32'd4;
                end
            end else if (redir) begin
                m_drop = 1;
            end
        end else if (m_have) begin
            if (redir) begin
                m_have = 0; m_req = 1;
            end else if (ifc.instr_ready) begin
                m_have = 0;
                if (halt) m_halt = 1;
                else      m_req  = 1;
            end
        end
        if (redir) m_pc = tgt;
    endtask

    // -------------------------------------------------------------------------
    // Memory responder: one outstanding read, response after a delay
    // -------------------------------------------------------------------------
    bit          e_busy = 0, e_rsp = 0, mem_rand = 0;
    int          e_cnt = 0, mem_delay = 0;
    logic [31:0] e_addr = 0, e_data = 0;

    task automatic env_step(input bit accepted, input logic [31:0] acc_addr);
        if (ifc.imem_rsp_valid) begin
            e_busy = 0;
        end else if (e_busy) begin
            // An in-flight read still answers right after a reset.
            if (reset)          e_cnt = 0;
            else if (e_cnt > 0) e_cnt--;
        end
        if (accepted) begin
            e_busy = 1;
            e_addr = acc_addr;
            e_cnt  = mem_rand ? int'($urandom_range(2, 0)) : mem_delay;
        end
        e_rsp  = e_busy && (e_cnt == 0);
        e_data = e_rsp ? (e_addr ^ DATA_MASK) : $urandom;
    endtask

    // Knobs for the next cycle
    bit          k_reset = 1, k_ready = 0, k_dec = 0, k_redir = 0, k_halt = 0;
    logic [31:0] k_tgt = 0;

    task automatic tick();
        bit          acc;
        logic [31:0] acc_addr;
        reset               = k_reset;
        ifc.imem_req_ready  = k_ready;
        ifc.instr_ready     = k_dec;
        redirect_valid      = k_redir;
        redirect_target     = k_tgt;
        halt                = k_halt;
        ifc.imem_rsp_valid  = e_rsp;
        ifc.imem_rsp_data   = e_data;
        @(posedge clk);
        acc      = m_req && ifc.imem_req_ready && !reset;
        acc_addr = m_pc;
        model_step();
        env_step(acc, acc_addr);
        #2;
    endtask

    // -------------------------------------------------------------------------
    // Per-cycle compare against the model
    // -------------------------------------------------------------------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("req_valid", 32'(ifc.imem_req_valid), 32'(m_req));
            if (m_req) check("req_addr", ifc.imem_req_addr, m_pc);
            check("instr_valid", 32'(ifc.instr_valid), 32'(m_have));
            check("instr_data", ifc.instr_data, m_idata);
            check("instr_pc", ifc.instr_pc, m_ipc);
            check("halted", 32'(halted), 32'(m_halt));
            check("pc", pc, m_pc);
        end
    end

    // -------------------------------------------------------------------------
    // Wrap test on the second instance (literal expectations)
    // -------------------------------------------------------------------------
    task automatic wrap_test();
        logic [31:0] wexp [3];
        int          n;
        bit          acc;
        logic [31:0] a;
        wexp[0] = 32'hFFFF_FFF8; wexp[1] = 32'hFFFF_FFFC; wexp[2] = 32'h0000_0000;
        reset_w = 1; ifw.imem_req_ready = 1; ifw.instr_ready = 1;
        ifw.imem_rsp_valid = 0; ifw.imem_rsp_data = 0;
        redirect_valid_w = 0; redirect_target_w = 0; halt_w = 0;
        repeat (2) @(posedge clk);
        #2 reset_w = 0;
        check("wrap_reset_pc", pc_w, 32'hFFFF_FFF8);
        n = 0; acc = 0; a = 0;
        for (int i = 0; i < 30 && n < 3; i++) begin
            @(negedge clk);
            if (ifw.instr_valid) begin
                check("wrap_instr_pc", ifw.instr_pc, wexp[n]);
                check("wrap_instr_data", ifw.instr_data, wexp[n] ^ DATA_MASK);
                n++;
            end
            acc = ifw.imem_req_valid;
            a   = ifw.imem_req_addr;
            @(posedge clk);
            #2;
            ifw.imem_rsp_valid = acc;
            ifw.imem_rsp_data  = a ^ DATA_MASK;
        end
        check("wrap_count", 32'(n), 32'd3);
        reset_w = 1;
    endtask

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        int          n, halt_cnt;
        int          gc [4];
        logic [31:0] gp [4], gd [4];
        bit          saw_iv;

        reset = 1; ifc.imem_req_ready = 0; ifc.instr_ready = 0;
        ifc.imem_rsp_valid = 0; ifc.imem_rsp_data = 0;
        redirect_valid = 0; redirect_target = 0; halt = 0;

        wrap_test();

        // Reset state
        k_reset = 1; tick(); chk_en = 1; tick(); k_reset = 0;
        check("rst_pc", pc, 32'h0);
        check("rst_req_valid", 32'(ifc.imem_req_valid), 32'd0);
        check("rst_instr_valid", 32'(ifc.instr_valid), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);

        // Zero-wait memory, ready decode: 0,4,8,C every 3 cycles
        k_ready = 1; k_dec = 1; mem_delay = 0;
        tick();
        check("first_req_valid", 32'(ifc.imem_req_valid), 32'd1);
        check("first_req_addr", ifc.imem_req_addr, 32'h0);
        n = 0;
        for (int c = 0; c < 14; c++) begin
            tick();
            if (ifc.instr_valid && n < 4) begin
                gp[n] = ifc.instr_pc; gd[n] = ifc.instr_data; gc[n] = c; n++;
            end
        end
        check("seq_count", 32'(n), 32'd4);
        for (int i = 0; i < n; i++) begin
            check("seq_pc", gp[i], 32'(4 * i));
            check("seq_data", gd[i], 32'(4 * i) ^ DATA_MASK);
            if (i > 0) check("seq_interval", 32'(gc[i] - gc[i-1]), 32'd3);
        end

        // Decode stall: held instruction stays put, no new request
        k_dec = 0;
        for (int i = 0; i < 10 && !ifc.instr_valid; i++) tick();
        check("hold_reached", 32'(ifc.instr_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_valid", 32'(ifc.instr_valid), 32'd1);
            check("hold_pc", ifc.instr_pc, 32'h10);
            check("hold_data", ifc.instr_data, 32'hA5A5_0010);
            check("hold_no_req", 32'(ifc.imem_req_valid), 32'd0);
        end
        k_dec = 1; tick();
        check("xfer_valid_low", 32'(ifc.instr_valid), 32'd0);
        check("xfer_next_req", 32'(ifc.imem_req_valid), 32'd1);
        check("xfer_next_addr", ifc.imem_req_addr, 32'h14);

        // Redirect while waiting on the response for pc=8
        k_reset = 1; tick(); k_reset = 0;
        mem_delay = 2;
        for (int i = 0; i < 40 && !(m_wait && m_pc == 32'h8); i++) tick();
        check("redir_setup", 32'(m_wait && m_pc == 32'h8), 32'd1);
        k_redir = 1; k_tgt = 32'h0000_0103; tick(); k_redir = 0;
        saw_iv = 0;
        for (int i = 0; i < 20 && !ifc.imem_req_valid; i++) begin
            tick();
            if (ifc.instr_valid) saw_iv = 1;
        end
        check("redir_dropped", 32'(saw_iv), 32'd0);
        check("redir_req_addr", ifc.imem_req_addr, 32'h100);
        for (int i = 0; i < 20 && !ifc.instr_valid; i++) tick();
        check("redir_instr_pc", ifc.instr_pc, 32'h100);
        check("redir_instr_data", ifc.instr_data, 32'hA5A5_0100);

        // Halt at a transfer; redirect ignored afterwards; reset recovers
        k_dec = 0; mem_delay = 0;
        for (int i = 0; i < 20 && !ifc.instr_valid; i++) tick();
        k_halt = 1; k_dec = 1; tick();
        check("halt_halted", 32'(halted), 32'd1);
        check("halt_valid_low", 32'(ifc.instr_valid), 32'd0);
        k_redir = 1; k_tgt = 32'h200; tick(); k_redir = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("halt_no_req", 32'(ifc.imem_req_valid), 32'd0);
        end
        check("halt_pc_kept", pc, 32'h104);
        k_halt = 0; k_reset = 1; tick(); k_reset = 0;
        check("unhalt_halted", 32'(halted), 32'd0);
        check("unhalt_pc", pc, 32'h0);

        // Reset while a read is in flight; its late response is ignored
        mem_delay = 3;
        for (int i = 0; i < 10 && !m_wait; i++) tick();
        k_reset = 1; tick(); k_reset = 0;
        tick();
        check("late_rsp_req", 32'(ifc.imem_req_valid), 32'd1);
        check("late_rsp_addr", ifc.imem_req_addr, 32'h0);
        check("late_rsp_no_instr", 32'(ifc.instr_valid), 32'd0);
        mem_delay = 0;
        for (int i = 0; i < 20 && !ifc.instr_valid; i++) tick();
        check("late_rsp_instr_pc", ifc.instr_pc, 32'h0);
        check("late_rsp_instr_data", ifc.instr_data, DATA_MASK);

        // Randomized traffic
        mem_rand = 1; halt_cnt = 0;
        for (int c = 0; c < 4000; c++) begin
            halt_cnt = m_halt ? halt_cnt + 1 : 0;
            k_reset  = ($urandom_range(119) == 0) || (halt_cnt > 5);
            k_ready  = ($urandom_range(3) != 0);
            k_dec    = ($urandom_range(2) != 0);
            k_redir  = ($urandom_range(9) == 0);
            k_tgt    = ($urandom_range(3) == 0) ? {28'hFFF_FFFF, 4'($urandom)} : $urandom;
            if (halt_cnt > 5)                k_halt = 0;
            else if ($urandom_range(39) == 0) k_halt = ~k_halt;
            tick();
        end

        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller that owns and sequences the program counter of the single-cycle-issue core. It issues one instruction-memory read at a time over a valid/ready request channel and captures the response. It hands the fetched word plus its address to decode over a valid/ready channel, and applies branch/jump redirects and halt. It sits between the core's control path, instruction memory and the decode stage, and replaces free-running PC update with a handshake-controlled sequence.

## Interface
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
- PC_STEP, 4, increment applied after each non-squashed fetch
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request when valid&ready at clk edge
- imem_req_addr  out  32  fetch address (= pc)
- imem_rsp_valid  in  1  response data valid (one-cycle pulse, exactly one per accepted request)
- imem_rsp_data  in  32  instruction word
- instr_valid  out  1  instruction available to decode
- instr_ready  in  1  decode accepts when valid&ready at clk edge
- instr_data  out  32  captured instruction word
- instr_pc  out  32  address of instr_data
- redirect_valid  in  1  branch/jump taken, single-cycle pulse
- redirect_target  in  32  new PC; bits [1:0] forced to 0 on load
- halt  in  1  level; stop fetching at next instruction boundary
- halted  out  1  sequencer stopped
- pc  out  32  current fetch PC

## Operation
- FSM states: IDLE, REQ, WAIT_RSP, HOLD, HALTED. All outputs come from registers or a direct decode of the state register.
- Reset (any state, any cycle, including mid-transaction): state=IDLE, pc=RESET_VECTOR, squash=0, instr_data=0, instr_pc=0. All valids and halted are 0. An in-flight memory response arriving after reset is ignored.
- IDLE: if halt=1 -> HALTED; else -> REQ.
- REQ: imem_req_valid=1, imem_req_addr=pc. On imem_req_ready -> WAIT_RSP.
- WAIT_RSP: on imem_rsp_valid with squash=0, the following happen together, then -> HOLD:
  - instr_data<=imem_rsp_data, instr_pc<=pc
  - pc<=pc+PC_STEP (mod 2^32, wrap 32'hFFFF_FFFC->0 for step 4)
- WAIT_RSP, on imem_rsp_valid with squash=1: discard data, squash<=0, -> REQ (pc already holds the target).
- HOLD: instr_valid=1, outputs stable until transfer. On instr_ready: if halt=1 -> HALTED, else -> REQ.
- HALTED: halted=1, no requests, redirects ignored; exit only via reset.
- Redirect (state IDLE/REQ/WAIT_RSP/HOLD): pc<={redirect_target[31:2],2'b00}. Per-state effect:
  - REQ without ready: stay REQ, new address presented next cycle; address may change while unaccepted.
  - REQ with ready same cycle: old-address request is accepted; squash<=1, -> WAIT_RSP.
  - WAIT_RSP without rsp: squash<=1. With rsp same cycle: response discarded, -> REQ.
  - HOLD: instruction is dropped (instr_valid low next cycle), -> REQ. If instr_ready in the same cycle, the transfer counts as done (decode consumed it) and redirect still applies.
  - Several redirects before the response: last target wins.
- Redirect has priority over halt in the same cycle, except in HALTED.

## Timing
- First edge with reset=0: IDLE->REQ; imem_req_valid high in the following cycle.
- Request accepted at edge N -> WAIT_RSP from N; rsp_valid at edge M -> instr_valid high from M (cycle after response).
- Transfer at edge K -> imem_req_valid high from K (next request).
- Zero-wait memory (ready=1, rsp one cycle after accept), ready decode: one instruction per 3 cycles.
- Redirect at edge R -> imem_req_addr=target visible from R when state is REQ.

## Test plan
- Reset, memory always ready, rsp 1 cycle later, data=addr^32'hA5A5_0000, decode always ready -> instr_pc sequence 0,4,8,C; instr_valid pulses every 3 cycles; data matches.
- RESET_VECTOR=32'hFFFF_FFF8 -> instr_pc FFFF_FFF8, FFFF_FFFC, 0000_0000 (wrap).
- Hold instr_ready=0 for 5 cycles in HOLD -> instr_valid, instr_data, instr_pc stable; no imem_req_valid until the transfer.
- Redirect to 32'h0000_0103 while in WAIT_RSP at pc=8 -> response for 8 discarded (no instr_valid); next request addr=0x100; next instr_pc=0x100.
- halt=1 while HOLD with instr_ready=1 -> transfer completes; halted=1 next cycle; no further requests; redirect pulse ignored; reset returns pc=RESET_VECTOR, halted=0.
- Reset asserted in WAIT_RSP, response arrives in the cycle after reset -> ignored; first post-reset request addr=RESET_VECTOR.
